// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared constants for the multi-cycle core.
//   - instruction opcodes (IR[31:26]) and R-type funct codes (IR[5:0])
//   - FSM state enum (also exported on the core's state_dbg port)
//   - ALU operation codes selected in DECODE and applied in EXEC
package mc_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_SLL = 3'd5,
    ALU_SRL = 3'd6
  } alu_op_t;

endpackage

// File: rtl/mc_microprocessor_regfile.sv
// mc_regfile: NREGS x DATA_W register file, r0 reads as zero.
//   clk              write clock
//   we/waddr/wdata   synchronous write port (writes to r0 dropped)
//   raddr_a/rdata_a  asynchronous read port A
//   raddr_b/rdata_b  asynchronous read port B
// Contents are not reset; only r0 has a defined value.
module mc_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (we && (waddr != '0)) regs[waddr] <= wdata;
  end

  assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/mc_microprocessor.sv
// mc_microprocessor: multi-cycle MIPS-like core, one instruction in flight.
//   clk, reset (async, active-high), enable (permits a new fetch)
//   imem_req/imem_addr/imem_rdata/imem_ready       instruction read port
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/
//   dmem_rdata/dmem_ready                          data port
//   pc, halted, trap                               status
//   state_dbg                                      current FSM state (state_t)
//
// Handshake (both memory ports): a transfer completes in the cycle where
// req && ready; ready may already be high in the first req cycle. From the
// cycle req rises until completion, req/addr/we/wdata do not change. Reset
// drops req combinationally and abandons the transfer.
module mc_microprocessor
  import mc_cpu_pkg::*;
#(
  parameter int          DATA_W   = 8,
  parameter int          NREGS    = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ready,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic [31:0]       pc,
  output logic              halted,
  output logic              trap,
  output logic [2:0]        state_dbg
);

  localparam int AW = $clog2(NREGS);

  state_t            state, state_nxt;
  logic [31:0]       ir, pc_r;
  logic [DATA_W-1:0] a_q, b_q, imm_q, res_q;
  alu_op_t           alu_op_q, dec_op;
  logic              trap_q, fetch_hold, dec_legal, rf_we;

  logic [5:0]        opcode, funct;
  logic [4:0]        shamt;
  logic [AW-1:0]     rs_a, rt_a, rd_a;
  logic [31:0]       imm32, br_target, j_target;
  logic [DATA_W-1:0] rdata_a, rdata_b, alu_b, alu_y;
  logic              take_br;

  assign opcode = ir[31:26];
  assign funct  = ir[5:0];
  assign shamt  = ir[10:6];
  assign rs_a   = ir[21 +: AW];
  assign rt_a   = ir[16 +: AW];
  assign rd_a   = ir[11 +: AW];
  assign imm32  = {{16{ir[15]}}, ir[15:0]};

  // pc_r already points past the branch when these are used in EXEC.
  assign br_target = pc_r + (imm32 << 2);
  assign j_target  = {pc_r[31:28], ir[25:0], 2'b00};

  mc_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_regfile (
    .clk     (clk),
    .we      (rf_we),
    .waddr   ((opcode == OP_RTYPE) ? rd_a : rt_a),
    .wdata   (res_q),
    .raddr_a (rs_a),
    .raddr_b (rt_a),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // Opcode/funct legality and ALU selection.
  always_comb begin
    dec_op    = ALU_ADD;
    dec_legal = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  dec_op = ALU_ADD;
          FN_SUB:  dec_op = ALU_SUB;
          FN_AND:  dec_op = ALU_AND;
          FN_OR:   dec_op = ALU_OR;
          FN_SLT:  dec_op = ALU_SLT;
          FN_SLL:  dec_op = ALU_SLL;
          FN_SRL:  dec_op = ALU_SRL;
          default: dec_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT: dec_op = ALU_ADD;
      default: dec_legal = 1'b0;
    endcase
  end

  // ALU. Shifts act on rt; a shift amount >= DATA_W yields zero by the
  // language's shift semantics.
  always_comb begin
    alu_b = (opcode == OP_RTYPE) ? b_q : imm_q;
    case (alu_op_q)
      ALU_ADD: alu_y = a_q + alu_b;
      ALU_SUB: alu_y = a_q - alu_b;
      ALU_AND: alu_y = a_q & alu_b;
      ALU_OR:  alu_y = a_q | alu_b;
      ALU_SLT: alu_y = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
      ALU_SLL: alu_y = b_q << shamt;
      ALU_SRL: alu_y = b_q >> shamt;
      default: alu_y = '0;
    endcase
  end

  assign take_br = ((opcode == OP_BEQ) && (a_q == b_q)) ||
                   ((opcode == OP_BNE) && (a_q != b_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    case (state)
      ST_FETCH: begin
        // fetch_hold keeps a started request alive if enable drops.
        imem_req = (enable || fetch_hold) && !reset;
        if (imem_req && imem_ready) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (!dec_legal || (opcode == OP_HALT)) state_nxt = ST_HALT;
        else                                   state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        case (opcode)
          OP_BEQ, OP_BNE, OP_J: state_nxt = ST_FETCH;
          OP_LW, OP_SW:         state_nxt = ST_MEM;
          default:              state_nxt = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_SW);
        if (dmem_ready) state_nxt = (opcode == OP_SW) ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        rf_we     = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      ir         <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      res_q      <= '0;
      alu_op_q   <= ALU_ADD;
      trap_q     <= 1'b0;
      fetch_hold <= 1'b0;
    end else begin
      fetch_hold <= imem_req && !imem_ready;
      case (state)
        ST_FETCH: begin
          if (imem_req && imem_ready) begin
            ir   <= imem_rdata;
            pc_r <= pc_r + 32'd4;
          end
        end
        ST_DECODE: begin
          a_q      <= rdata_a;
          b_q      <= rdata_b;
          imm_q    <= imm32[DATA_W-1:0];
          alu_op_q <= dec_op;
          if (!dec_legal) trap_q <= 1'b1;
        end
        ST_EXEC: begin
          res_q <= alu_y;
          if (opcode == OP_J) pc_r <= j_target;
          else if (take_br)   pc_r <= br_target;
        end
        ST_MEM: begin
          if (dmem_ready && (opcode == OP_LW)) res_q <= dmem_rdata;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = pc_r;
  assign dmem_addr  = res_q;
  assign dmem_wdata = b_q;
  assign pc         = pc_r;
  assign halted     = (state == ST_HALT);
  assign trap       = trap_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_mc_microprocessor.sv
// Bench for mc_microprocessor (DATA_W=8, NREGS=32, RESET_PC=0).
// Programs are loaded into a behavioral instruction memory; register
// results are observed through stores, which a negedge monitor compares
// against an expected queue. Fetch addresses are checked the same way
// while chk_fetch is set.
module tb_mc_microprocessor;

  localparam int DATA_W = 8;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic              clk = 1'b0;
  logic              reset, enable;
  logic              imem_req, imem_ready;
  logic [31:0]       imem_addr, imem_rdata;
  logic              dmem_req, dmem_we, dmem_ready;
  logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0]       pc;
  logic              halted, trap;
  logic [2:0]        state_dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mc_microprocessor #(.DATA_W(DATA_W), .NREGS(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .pc(pc), .halted(halted), .trap(trap), .state_dbg(state_dbg)
  );

  // ---------------- memory models ----------------
  logic [31:0]       imem [0:255];
  logic [DATA_W-1:0] dmem [0:255];
  int imem_wait = 0, dmem_wait = 0, icnt = 0, dcnt = 0;

  assign imem_ready = imem_req && (icnt >= imem_wait);
  assign dmem_ready = dmem_req && (dcnt >= dmem_wait);
  assign imem_rdata = imem[imem_addr[9:2]];
  assign dmem_rdata = dmem[dmem_addr];

  always @(posedge clk) begin
    icnt <= (imem_req && !imem_ready) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
    if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr] <= dmem_wdata;
  end

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];    // expected stores {addr, data}
  logic [31:0] exp_f_q[$];  // expected fetch addresses
  bit          chk_fetch = 1'b0;
  int          checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  logic              prev_dwait = 1'b0, prev_iwait = 1'b0, prev_we = 1'b0;
  logic [DATA_W-1:0] prev_daddr, prev_wdata;
  logic [31:0]       prev_iaddr;
  logic [15:0]       st_e;
  logic [31:0]       f_e;

  always @(negedge clk) begin
    if (reset) begin
      prev_dwait = 1'b0;
      prev_iwait = 1'b0;
    end else begin
      if (prev_dwait && dmem_req) begin
        check("dmem_addr_stable", 32'(dmem_addr), 32'(prev_daddr));
        check("dmem_wdata_stable", 32'(dmem_wdata), 32'(prev_wdata));
        check("dmem_we_stable", 32'(dmem_we), 32'(prev_we));
      end
      if (prev_iwait && imem_req) check("imem_addr_stable", imem_addr, prev_iaddr);
      if (dmem_req && dmem_ready && dmem_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL store_unexpected actual=%0h/%0h expected=none", dmem_addr, dmem_wdata);
        end else begin
          st_e = exp_q.pop_front();
          check("store", 32'({dmem_addr, dmem_wdata}), 32'(st_e));
        end
      end
      if (chk_fetch && imem_req && imem_ready) begin
        if (exp_f_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected actual=%0h expected=none", imem_addr);
        end else begin
          f_e = exp_f_q.pop_front();
          check("fetch_addr", imem_addr, f_e);
        end
      end
      prev_dwait = dmem_req && !dmem_ready;
      prev_daddr = dmem_addr;
      prev_wdata = dmem_wdata;
      prev_we    = dmem_we;
      prev_iwait = imem_req && !imem_ready;
      prev_iaddr = imem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  task automatic load_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    chk_fetch = 1'b0;
    imem_wait = 0;
    dmem_wait = 0;
    for (int i = 0; i < 256; i++) imem[i] = HALT_W;
    repeat (2) @(negedge clk);
  endtask

  // Release mid high-phase so the following negedge sees the first request.
  task automatic release_run(input logic en);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = en;
  endtask

  task automatic run_to_halt(input int limit, output int cyc);
    cyc = 0;
    while (!halted && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!halted) begin
      checks++;
      errors++;
      $display("FAIL halt_timeout actual=%0d expected=halted", cyc);
    end
  endtask

  // ---------------- tests ----------------
  int cyc, idle_req;

  initial begin
    // T1: reset state, then addi/addi/add/halt timing
    load_reset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1] = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
    imem[2] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
    imem[3] = HALT_W;
    enable = 1'b1;
    #1;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_dmem_we", 32'(dmem_we), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_state", 32'(state_dbg), 32'd0);
    release_run(1'b1);
    run_to_halt(100, cyc);
    check("t1_cycles", cyc, 32'd14);
    check("t1_trap", 32'(trap), 32'd0);
    check("t1_pc", pc, 32'h10);
    #2;
    check("t1_halt_no_imem_req", 32'(imem_req), 32'd0);

    // T1b: ALU ops observed through stores, incl. r0 write discard
    load_reset();
    imem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'd3);
    imem[2]  = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);   // add  -> 8
    imem[3]  = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);   // sub  -> 2
    imem[4]  = enc_r(5'd1, 5'd2, 5'd5, 5'd0, 6'h24);   // and  -> 1
    imem[5]  = enc_r(5'd1, 5'd2, 5'd6, 5'd0, 6'h25);   // or   -> 7
    imem[6]  = enc_r(5'd0, 5'd1, 5'd7, 5'd3, 6'h00);   // sll 3 -> 0x28
    imem[7]  = enc_r(5'd0, 5'd1, 5'd8, 5'd1, 6'h02);   // srl 1 -> 2
    imem[8]  = enc_r(5'd0, 5'd1, 5'd9, 5'd8, 6'h00);   // sll 8 -> 0
    imem[9]  = enc_i(6'h08, 5'd0, 5'd0, 16'd7);        // addi r0 discarded
    imem[10] = enc_i(6'h2B, 5'd0, 5'd3, 16'd0);
    imem[11] = enc_i(6'h2B, 5'd0, 5'd4, 16'd1);
    imem[12] = enc_i(6'h2B, 5'd0, 5'd5, 16'd2);
    imem[13] = enc_i(6'h2B, 5'd0, 5'd6, 16'd3);
    imem[14] = enc_i(6'h2B, 5'd0, 5'd7, 16'd4);
    imem[15] = enc_i(6'h2B, 5'd0, 5'd8, 16'd5);
    imem[16] = enc_i(6'h2B, 5'd0, 5'd9, 16'd6);
    imem[17] = enc_i(6'h2B, 5'd0, 5'd0, 16'd7);
    exp_q.push_back(16'h00_08); exp_q.push_back(16'h01_02);
    exp_q.push_back(16'h02_01); exp_q.push_back(16'h03_07);
    exp_q.push_back(16'h04_28); exp_q.push_back(16'h05_02);
    exp_q.push_back(16'h06_00); exp_q.push_back(16'h07_00);
    release_run(1'b1);
    run_to_halt(200, cyc);
    check("t1b_stores_drained", 32'(exp_q.size()), 32'd0);

    // T2: 8-bit wrap and signed slt
    load_reset();
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h007F);
    imem[1] = enc_i(6'h08, 5'd1, 5'd1, 16'h0001);
    imem[2] = enc_r(5'd1, 5'd0, 5'd2, 5'd0, 6'h2A);   // slt r2,r1,r0 -> 1
    imem[3] = enc_r(5'd0, 5'd1, 5'd3, 5'd0, 6'h2A);   // slt r3,r0,r1 -> 0
    imem[4] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0020);
    imem[5] = enc_i(6'h2B, 5'd0, 5'd2, 16'h0021);
    imem[6] = enc_i(6'h2B, 5'd0, 5'd3, 16'h0022);
    exp_q.push_back(16'h20_80); exp_q.push_back(16'h21_01); exp_q.push_back(16'h22_00);
    release_run(1'b1);
    run_to_halt(100, cyc);
    check("t2_stores_drained", 32'(exp_q.size()), 32'd0);

    // T3: sw/lw with 3 data wait cycles each: 4 + 7 + 8 + 7 + 2 cycles
    load_reset();
    dmem_wait = 3;
    dmem[8'h10] = 8'h00;
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h00A5);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0010);
    imem[2] = enc_i(6'h23, 5'd0, 5'd4, 16'h0010);
    imem[3] = enc_i(6'h2B, 5'd0, 5'd4, 16'h0011);
    exp_q.push_back(16'h10_A5); exp_q.push_back(16'h11_A5);
    release_run(1'b1);
    run_to_halt(100, cyc);
    check("t3_cycles", cyc, 32'd28);
    check("t3_stores_drained", 32'(exp_q.size()), 32'd0);

    // T4: bne not taken, j to 0x20, beq r0,r0,-1 loops on 0x20
    load_reset();
    imem[0] = enc_i(6'h05, 5'd0, 5'd0, 16'd3);
    imem[1] = {6'h02, 26'd8};
    imem[8] = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    exp_f_q.push_back(32'h00); exp_f_q.push_back(32'h04);
    exp_f_q.push_back(32'h20); exp_f_q.push_back(32'h20); exp_f_q.push_back(32'h20);
    chk_fetch = 1'b1;
    release_run(1'b1);
    cyc = 0;
    while (exp_f_q.size() != 0 && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk_fetch = 1'b0;
    check("t4_fetch_cycles", cyc, 32'd13);
    check("t4_halted", 32'(halted), 32'd0);

    // T5: enable low keeps core idle; held request; illegal opcode traps
    load_reset();
    imem[0] = {6'h3E, 26'd0};
    release_run(1'b0);
    idle_req = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req) idle_req++;
    end
    check("t5_idle_imem_req", idle_req, 32'd0);
    check("t5_idle_pc", pc, 32'h0);
    check("t5_idle_state", 32'(state_dbg), 32'd0);
    imem_wait = 2;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    run_to_halt(20, cyc);
    check("t5_trap", 32'(trap), 32'd1);
    check("t5_pc", pc, 32'h4);

    // T5b: illegal R-type funct traps
    load_reset();
    imem[0] = enc_r(5'd0, 5'd0, 5'd1, 5'd0, 6'h3F);
    release_run(1'b1);
    run_to_halt(20, cyc);
    check("t5b_trap", 32'(trap), 32'd1);

    // T6: reset during a pending store abandons it
    load_reset();
    dmem_wait = 20;
    dmem[8'h30] = 8'h33;
    imem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h005A);
    imem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0030);
    release_run(1'b1);
    cyc = 0;
    while (!dmem_req && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("t6_store_started", 32'(dmem_req), 32'd1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_dmem_req", 32'(dmem_req), 32'd0);
    check("t6_rst_dmem_we", 32'(dmem_we), 32'd0);
    check("t6_rst_imem_req", 32'(imem_req), 32'd0);
    check("t6_rst_pc", pc, 32'h0);
    repeat (3) @(negedge clk);
    check("t6_mem_unchanged", 32'(dmem[8'h30]), 32'h33);
    check("t6_no_store_pending", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_microprocessor.md
MC_MICROPROCESSOR -- requirements
Module: mc_microprocessor

Interface
REQ-001 Parameter DATA_W, 8: datapath, register and data-memory word width (8..32).
REQ-002 Parameter NREGS, 32: register count, power of two, 2..32; register fields use the low log2(NREGS) bits.
REQ-003 Parameter RESET_PC, 0: 32-bit PC value loaded on reset.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 enable  in  1  permits a new instruction fetch.
REQ-007 imem_req / imem_addr / imem_rdata / imem_ready  out 1 / out 32 / in 32 / in 1  instruction read port.
REQ-008 dmem_req / dmem_we / dmem_addr / dmem_wdata / dmem_rdata / dmem_ready  out 1 / out 1 / out DATA_W / out DATA_W / in DATA_W / in 1  data port.
REQ-009 pc  out 32  current PC; halted  out 1  core stopped; trap  out 1  stopped on illegal opcode.

Function
REQ-010 Multi-cycle FSM, states FETCH, DECODE, EXEC, MEM, WB, HALT; one instruction in flight.
REQ-011 Handshake: a transfer completes in the cycle req&ready is high; ready may be high in the same cycle as req (zero wait); req, addr, we and wdata stay constant from assertion until completion.
REQ-012 FETCH: when enable=1, imem_req=1, imem_addr=pc; on completion latch IR, pc<=pc+4, go DECODE. When enable=0 and no request is outstanding, stay in FETCH with imem_req=0; once asserted, a request is held to completion regardless of enable.
REQ-013 DECODE: latch rs/rt operands; r0 reads 0; immediate = IR[15:0] sign-extended or truncated to DATA_W.
REQ-014 Opcode IR[31:26]: 0x00 R-type, 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j, 0x3F halt; any other opcode -> HALT with trap=1.
REQ-015 R-type funct IR[5:0]: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0), 0x00 sll, 0x02 srl (shamt IR[10:6]; shamt >= DATA_W gives 0); other funct -> HALT, trap=1.
REQ-016 Arithmetic is modulo 2^DATA_W; no overflow exception.
REQ-017 Branch/jump resolve in EXEC, then FETCH: beq/bne target = pc + (sext(IR[15:0])<<2) (pc already +4); j target = {pc[31:28], IR[25:0], 2'b00}.
REQ-018 lw/sw: EXEC computes addr = rs + imm; MEM issues dmem_req (dmem_we=1 and wdata=rt for sw); sw ends at completion -> FETCH; lw -> WB.
REQ-019 WB writes rd (R-type, IR[15:11]) or rt (addi, lw); writes to r0 discarded; register indices masked to log2(NREGS) bits.
REQ-020 Cycle counts with zero-wait memory: j/beq/bne 3, R-type/addi 4, sw 4, lw 5; each memory wait cycle adds one.
REQ-021 halt: DECODE -> HALT, trap=0; HALT is absorbing until reset; halted=1, no requests issued.
REQ-022 PC wraps modulo 2^32; fetch addresses with pc[1:0] != 0 are not possible by construction.

Reset
REQ-023 On reset: state=FETCH, pc=RESET_PC, imem_req=dmem_req=dmem_we=0, halted=0, trap=0, IR=0; register contents undefined except r0=0.
REQ-024 Reset asserted mid-transaction drops req immediately; the interrupted transfer is abandoned and a store is not retried.

Structure
REQ-025 Package mc_cpu_pkg holds opcode and funct constants, the FSM state enum and ALU operation codes.
REQ-026 One sub-module, mc_regfile (NREGS x DATA_W, 2 async read ports, 1 sync write port, r0 hardwired to zero); ALU is inline.

Verification
REQ-027 Zero-wait memory, addi r1,r0,5; addi r2,r0,3; add r3,r1,r2; halt -> r3=8, halted=1, trap=0 after 4+4+4+2 cycles.
REQ-028 DATA_W=8: addi r1,r0,0x7F; addi r1,r1,1 -> r1=0x80; slt r2,r1,r0 -> r2=1.
REQ-029 sw r1 (0xA5) to 0x10, lw r4 from 0x10 with dmem_ready delayed 3 cycles -> r4=0xA5; lw takes 8 cycles; dmem_addr/wdata stable throughout the wait.
REQ-030 beq r0,r0,-1 at pc 0x20 -> next fetch at 0x20; bne r0,r0 taken path never fetched.
REQ-031 enable=0 in FETCH for 10 cycles -> imem_req=0, pc unchanged; opcode 0x3E -> halted=1, trap=1.
REQ-032 Reset asserted during a pending sw -> dmem_req=0 in the same cycle, pc=RESET_PC, memory unchanged.
